// File: rtl/counter_pkg.sv
// Shared definitions for the 0-99 counter run-control block.
package counter_pkg;

    // Run/pause sequencer states, encoded as they appear on run_state.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } run_state_e;

    // Counter datapath width and range.
    localparam int CNT_W   = 7;
    localparam int CNT_MAX = 99;

    // Default preset values for the load strobe.
    localparam int LOAD_UP_DEFAULT = 90;
    localparam int LOAD_DN_DEFAULT = 10;

endpackage

// File: rtl/btn_debounce.sv
// Synchroniser plus stability counter for one raw board input.
// level_o follows the input once it has been steady for DB_CYCLES
// synchronised samples; rise_o pulses for one clock on the accepted
// 0->1 transition, in the same cycle level_o rises.
module btn_debounce #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic [CW-1:0] stab_q, stab_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;

    // Two-flop synchroniser for the asynchronous raw input.
    // NOTE: flops use non-blocking assignments so each stage samples the pre-edge value of the one before it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive samples that disagree with the accepted level; flip after DB_CYCLES of them.
    // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch appears.
    always_comb begin
        stab_d  = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (stab_q == CNT_LAST) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
            end else begin
                stab_d = stab_q + 1'b1;
            end
        end
    end

    // Stability counter, accepted level and edge pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stab_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            stab_q  <= stab_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/counter_ctrl.sv
// Run-control sequencer for the 0-99 up/down counter: debounced buttons,
// start/stop FSM, tick prescaler, direction register, load strobe and
// rollover buzzer timer. Every output comes straight from a flop.
module counter_ctrl
    import counter_pkg::*;
#(
    parameter int CLK_HZ      = 50000000,
    parameter int TICK_HZ     = 1,
    parameter int DB_CYCLES   = 500000,
    parameter int BUZZ_CYCLES = 25000000,
    parameter int LOAD_UP     = LOAD_UP_DEFAULT,
    parameter int LOAD_DN     = LOAD_DN_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_start,
    input  logic             btn_stop,
    input  logic             btn_load,
    input  logic             sw_updown,
    input  logic             cnt_wrap,
    output logic             cnt_tick,
    output logic             cnt_dir,
    output logic             cnt_load,
    output logic [CNT_W-1:0] cnt_load_val,
    output logic             cnt_clear,
    output logic [1:0]       run_state,
    output logic             buzzer
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW  = $clog2(BUZZ_CYCLES + 1);
    localparam logic [PW-1:0]    PRESC_TC  = PW'(DIV - 1);
    localparam logic [BW-1:0]    BUZZ_LOAD = BW'(BUZZ_CYCLES);
    localparam logic [CNT_W-1:0] VAL_UP    = CNT_W'(LOAD_UP);
    localparam logic [CNT_W-1:0] VAL_DN    = CNT_W'(LOAD_DN);

    // Debouncer lane assignment.
    localparam int I_START = 0;
    localparam int I_STOP  = 1;
    localparam int I_LOAD  = 2;
    localparam int I_SW    = 3;

    logic [3:0] raw_in, db_level, db_rise;
    logic       start_press, stop_press, load_press, sw_level;

    assign raw_in = {sw_updown, btn_load, btn_stop, btn_start};

    for (genvar i = 0; i < 4; i++) begin : g_db
        btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk     (clk),
            .rst_n   (rst_n),
            .raw_i   (raw_in[i]),
            .level_o (db_level[i]),
            .rise_o  (db_rise[i])
        );
    end

    assign start_press = db_rise[I_START];
    assign stop_press  = db_rise[I_STOP];
    assign load_press  = db_rise[I_LOAD];
    assign sw_level    = db_level[I_SW];

    // Button levels and the switch edge have no consumer here.
    logic unused_db;
    assign unused_db = ^{db_level[I_LOAD], db_level[I_STOP], db_level[I_START], db_rise[I_SW]};

    run_state_e       state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [BW-1:0]    buzz_q, buzz_d;
    logic             tick_q, tick_d;
    logic             dir_q, dir_d;
    logic             load_q, load_d;
    logic [CNT_W-1:0] load_val_q, load_val_d;
    logic             clear_q, clear_d;
    logic             buzzer_q, buzzer_d;

    // Next state for the FSM, prescaler, direction, load/clear strobes and buzzer timer.
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        tick_d     = 1'b0;
        buzz_d     = buzz_q;

        // Stop outranks start when both arrive together.
        case (state_q)
            ST_IDLE:  if (start_press && !stop_press) state_d = ST_RUN;
            ST_RUN:   if (stop_press)                 state_d = ST_PAUSE;
            ST_PAUSE: if (start_press && !stop_press) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase

        // Prescaler runs in RUN, holds in PAUSE so the partial period resumes, sits at 0 in IDLE.
        case (state_q)
            ST_RUN: begin
                if (presc_q == PRESC_TC) begin
                    presc_d = '0;
                    tick_d  = !load_press;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            ST_PAUSE: presc_d = presc_q;
            default:  presc_d = '0;
        endcase

        // Direction only moves while idle or right after a tick, never alongside one.
        dir_d = (state_q == ST_IDLE || tick_q) ? sw_level : dir_q;

        load_d     = load_press;
        load_val_d = load_press ? (dir_d ? VAL_UP : VAL_DN) : '0;
        clear_d    = (state_d == ST_IDLE) && !load_press;

        // Wrap (re)arms the buzzer unless idle; otherwise it counts down to zero.
        if (cnt_wrap && state_q != ST_IDLE) begin
            buzz_d = BUZZ_LOAD;
        end else if (buzz_q != '0) begin
            buzz_d = buzz_q - 1'b1;
        end
        buzzer_d = (buzz_d != '0);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            buzz_q     <= '0;
            tick_q     <= 1'b0;
            dir_q      <= 1'b0;
            load_q     <= 1'b0;
            load_val_q <= '0;
            clear_q    <= 1'b1;
            buzzer_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            buzz_q     <= buzz_d;
            tick_q     <= tick_d;
            dir_q      <= dir_d;
            load_q     <= load_d;
            load_val_q <= load_val_d;
            clear_q    <= clear_d;
            buzzer_q   <= buzzer_d;
        end
    end

    assign cnt_tick     = tick_q;
    assign cnt_dir      = dir_q;
    assign cnt_load     = load_q;
    assign cnt_load_val = load_val_q;
    assign cnt_clear    = clear_q;
    assign run_state    = state_q;
    assign buzzer       = buzzer_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl with small timing parameters.
module tb_counter_ctrl;

    localparam int CLK_HZ  = 20;
    localparam int TICK_HZ = 1;
    localparam int DB      = 4;
    localparam int BUZZ    = 6;
    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int L_UP    = 90;
    localparam int L_DN    = 10;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_start = 1'b0, btn_stop = 1'b0, btn_load = 1'b0;
    logic       sw_updown = 1'b1, cnt_wrap = 1'b0;
    logic       cnt_tick, cnt_dir, cnt_load, cnt_clear, buzzer;
    logic [6:0] cnt_load_val;
    logic [1:0] run_state;

    int n_checks = 0;
    int n_fail   = 0;
    int load_seen = 0;

    always #5 clk = ~clk;

    counter_ctrl #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DB_CYCLES(DB), .BUZZ_CYCLES(BUZZ),
        .LOAD_UP(L_UP), .LOAD_DN(L_DN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_stop(btn_stop),
        .btn_load(btn_load), .sw_updown(sw_updown), .cnt_wrap(cnt_wrap),
        .cnt_tick(cnt_tick), .cnt_dir(cnt_dir), .cnt_load(cnt_load),
        .cnt_load_val(cnt_load_val), .cnt_clear(cnt_clear),
        .run_state(run_state), .buzzer(buzzer)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Debounce: an input is accepted once the last DB synchronised samples
    // (raw delayed by two clocks) all differ from the current level.
    logic [DB+1:0] m_hist[4];
    bit   m_lvl[4], m_prs[4];
    int   m_state, m_phase, m_buzz, e_val;
    bit   m_dir, e_tick, e_load, e_clear, e_buzz;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_hist[i] = '0; m_lvl[i] = 0; m_prs[i] = 0;
        end
        m_state = S_IDLE; m_phase = 0; m_buzz = 0; e_val = 0;
        m_dir = 0; e_tick = 0; e_load = 0; e_clear = 1; e_buzz = 0;
    endtask

    task automatic model_step();
        bit raw[4];
        int st;
        bit due;
        logic [DB+1:0] h;
        logic [DB-1:0] win;
        raw = '{btn_start, btn_stop, btn_load, sw_updown};
        st  = m_state;
        due = (st == S_RUN) && (m_phase == DIV - 1);
        if (st == S_IDLE || e_tick) m_dir = m_lvl[3];
        e_tick = due && !m_prs[2];
        e_load = m_prs[2];
        if (st == S_RUN) m_phase = (m_phase + 1) % DIV;
        else if (st == S_IDLE) m_phase = 0;
        if (m_prs[1]) begin
            if (st == S_RUN) m_state = S_PAUSE;
        end else if (m_prs[0] && st != S_RUN) begin
            m_state = S_RUN;
        end
        e_clear = (m_state == S_IDLE) && !e_load;
        e_val   = e_load ? (m_dir ? L_UP : L_DN) : 0;
        if (cnt_wrap && st != S_IDLE) m_buzz = BUZZ;
        else if (m_buzz > 0) m_buzz--;
        e_buzz = (m_buzz > 0);
        for (int i = 0; i < 4; i++) begin
            h = {m_hist[i][DB:0], raw[i]};
            m_hist[i] = h;
            win = h[DB+1:2];
            m_prs[i] = 0;
            if (!m_lvl[i] && (&win)) begin
                m_lvl[i] = 1; m_prs[i] = 1;
            end else if (m_lvl[i] && (win == '0)) begin
                m_lvl[i] = 0;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // Every clock out of reset, all outputs are compared with the model.
    always @(negedge clk) begin
        if (rst_n) begin
            check("tick",     cnt_tick,     e_tick);
            check("dir",      cnt_dir,      m_dir);
            check("load",     cnt_load,     e_load);
            check("load_val", cnt_load_val, e_val);
            check("clear",    cnt_clear,    e_clear);
            check("state",    run_state,    m_state);
            check("buzzer",   buzzer,       e_buzz);
            if (cnt_load) load_seen++;
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [1:0] sig(input int sel);
        case (sel)
            0:       return {1'b0, cnt_tick};
            1:       return {1'b0, cnt_load};
            2:       return run_state;
            default: return {1'b0, buzzer};
        endcase
    endfunction

    // Counts falling edges until the selected output equals val; n == limit on timeout.
    task automatic wait_sig(input int sel, input logic [1:0] val, input int limit, output int n);
        n = 0;
        while (n < limit) begin
            @(negedge clk);
            n++;
            if (sig(sel) === val) break;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic press(input bit s, input bit p, input bit l);
        @(negedge clk);
        btn_start = s; btn_stop = p; btn_load = l;
        repeat (8) @(negedge clk);
        btn_start = 0; btn_stop = 0; btn_load = 0;
        repeat (10) @(negedge clk);
    endtask

    typedef struct {
        bit         start;
        bit         stop;
        bit         load;
        logic [1:0] exp_state;
    } vec_t;

    vec_t tbl[12];

    task automatic buzz_run(input bit dbl, output int ones);
        ones = 0;
        for (int i = 0; i < 14; i++) begin
            cnt_wrap = (i == 0) || (dbl && i == 3);
            @(negedge clk);
            if (buzzer) ones++;
        end
        cnt_wrap = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, l0, cnt;

        tbl[0]  = '{0, 1, 0, S_IDLE};
        tbl[1]  = '{1, 1, 0, S_IDLE};
        tbl[2]  = '{0, 0, 1, S_IDLE};
        tbl[3]  = '{1, 0, 0, S_RUN};
        tbl[4]  = '{1, 0, 0, S_RUN};
        tbl[5]  = '{0, 0, 1, S_RUN};
        tbl[6]  = '{1, 1, 0, S_PAUSE};
        tbl[7]  = '{0, 1, 0, S_PAUSE};
        tbl[8]  = '{1, 1, 0, S_PAUSE};
        tbl[9]  = '{0, 0, 1, S_PAUSE};
        tbl[10] = '{1, 0, 0, S_RUN};
        tbl[11] = '{0, 1, 0, S_PAUSE};

        // Reset values while rst_n is held low.
        repeat (2) @(negedge clk);
        #1;
        check("rst_tick",     cnt_tick, 0);
        check("rst_dir",      cnt_dir, 0);
        check("rst_load",     cnt_load, 0);
        check("rst_load_val", cnt_load_val, 0);
        check("rst_clear",    cnt_clear, 1);
        check("rst_state",    run_state, S_IDLE);
        check("rst_buzzer",   buzzer, 0);
        #1 rst_n = 1'b1;

        // FSM transition table, including simultaneous start+stop.
        for (int i = 0; i < 12; i++) begin
            l0 = load_seen;
            press(tbl[i].start, tbl[i].stop, tbl[i].load);
            check($sformatf("tbl%0d_state", i), run_state, tbl[i].exp_state);
            check($sformatf("tbl%0d_loads", i), load_seen - l0, tbl[i].load);
        end

        // Start latency, first tick and tick period.
        do_reset();
        @(negedge clk);
        btn_start = 1;
        wait_sig(2, S_RUN, 30, n);
        check("start_latency", n, 7);
        check("clear_dropped", cnt_clear, 0);
        repeat (3) @(negedge clk);
        btn_start = 0;
        wait_sig(0, 2'd1, 40, n);
        check("first_tick", n + 3, DIV);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("tick_width", cnt_tick, 0);
            wait_sig(0, 2'd1, 40, n);
            check("tick_period", n + 1, DIV);
        end

        // Short start glitch, then stop 8 clocks before a tick, then resume.
        @(negedge clk);
        btn_start = 1;
        repeat (3) @(negedge clk);
        btn_start = 0;
        repeat (6) @(negedge clk);
        check("glitch_ignored", run_state, S_RUN);
        wait_sig(0, 2'd1, 40, n);
        repeat (5) @(negedge clk);
        btn_stop = 1;
        wait_sig(2, S_PAUSE, 30, n);
        check("stop_latency", n, 7);
        repeat (3) @(negedge clk);
        btn_stop = 0;
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (cnt_tick) cnt++;
        end
        check("pause_no_tick", cnt, 0);
        @(negedge clk);
        btn_start = 1;
        wait_sig(2, S_RUN, 30, n);
        check("restart_latency", n, 7);
        wait_sig(0, 2'd1, 30, n);
        check("resume_partial_period", n, 8);
        btn_start = 0;

        // Load press landing on a tick clock in up mode.
        wait_sig(0, 2'd1, 40, n);
        repeat (13) @(negedge clk);
        btn_load = 1;
        repeat (7) @(negedge clk);
        check("load_on_tick", cnt_load, 1);
        check("load_on_tick_val", cnt_load_val, L_UP);
        check("load_on_tick_no_tick", cnt_tick, 0);
        check("load_on_tick_dir", cnt_dir, 1);
        repeat (3) @(negedge clk);
        btn_load = 0;
        repeat (8) @(negedge clk);

        // Down mode: direction follows after a tick, then load gives LOAD_DN.
        sw_updown = 0;
        repeat (10) @(negedge clk);
        wait_sig(0, 2'd1, 40, n);
        repeat (2) @(negedge clk);
        check("dir_after_tick", cnt_dir, 0);
        btn_load = 1;
        wait_sig(1, 2'd1, 20, n);
        check("load_dn_latency", n, 7);
        check("load_dn_val", cnt_load_val, L_DN);
        repeat (4) @(negedge clk);
        btn_load = 0;
        repeat (8) @(negedge clk);

        // Buzzer: single wrap, then retrigger 3 clocks later.
        buzz_run(0, cnt);
        check("buzz_single", cnt, BUZZ);
        buzz_run(1, cnt);
        check("buzz_retrigger", cnt, BUZZ + 3);

        // Asynchronous reset mid-buzz and mid-run.
        @(negedge clk);
        cnt_wrap = 1;
        @(negedge clk);
        cnt_wrap = 0;
        @(negedge clk);
        check("pre_reset_buzzing", buzzer, 1);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_buzzer", buzzer, 0);
        check("async_rst_tick",   cnt_tick, 0);
        check("async_rst_state",  run_state, S_IDLE);
        check("async_rst_clear",  cnt_clear, 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // Wrap in IDLE is ignored.
        buzz_run(0, cnt);
        check("buzz_idle_ignored", cnt, 0);

        // Random stimulus against the model.
        for (int it = 0; it < 300; it++) begin
            int sel, hold;
            sel  = $urandom_range(0, 5);
            hold = $urandom_range(1, 12);
            @(negedge clk);
            case (sel)
                0: btn_start = 1'($urandom_range(0, 1));
                1: btn_stop  = 1'($urandom_range(0, 1));
                2: btn_load  = 1'($urandom_range(0, 1));
                3: sw_updown = 1'($urandom_range(0, 1));
                4: begin
                    cnt_wrap = 1;
                    @(negedge clk);
                    cnt_wrap = 0;
                end
                default: ;
            endcase
            repeat (hold) @(negedge clk);
        end
        btn_start = 0; btn_stop = 0; btn_load = 0;
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
